cook_timer_sec: RTL and testbench
=================================

Name: cook_timer_sec

Overview:
- Countdown (kitchen) timer for the multi-purpose watch; it runs in the opposite direction to the stopwatch mode.
- User sets MM:SS with buttons, starts the timer, and it counts down once per second to 00:00, then raises an alarm.
- Output is a 16-bit packed BCD word {min10, min1, sec10, sec1} for the shared FND display mux. Buttons arrive as single-cycle debounced rising-edge pulses.

Parameters:
- TICKS_PER_SEC, 100000000, clk cycles per one-second decrement; the bench overrides it to a small value.
- ALARM_SEC, 10, seconds the alarm stays asserted before auto-return to idle.

Ports:
- clk  input  1  system clock
- reset_p  input  1  asynchronous active-high reset
- btn_pedge  input  4  one-cycle button pulses: [0] start/pause, [1] sec +1, [2] min +1, [3] clear/stop
- value  output  16  BCD display word {min10, min1, sec10, sec1}
- alarm  output  1  high while the alarm is sounding
- running  output  1  high while in RUN

Behaviour:
- Clock and reset: one clock, clk. Reset_p is asynchronous and active-high. All state registers are on posedge clk or posedge reset_p.
- On reset: state = IDLE; set_time, count, prescaler and alarm counter = 0. Outputs value = 16'h0000, alarm = 0, running = 0.
- Encoding: set_time and count are each 4 BCD digits. No digit ever holds a value above 9. sec10 never exceeds 5.
- value is set_time in IDLE and count in RUN, PAUSE and ALARM. In ALARM, count = 0000.
- alarm = (state == ALARM). running = (state == RUN). Both are decoded from the registered state.
- Button priority when several pulse in the same cycle: [3] > [0] > [2] > [1]. Only the highest-priority button acts.
- IDLE:
  - btn[1]: seconds field of set_time +1, wrapping 59 -> 00 with no carry into minutes.
  - btn[2]: minutes field +1, wrapping 99 -> 00.
  - btn[3]: set_time = 0000.
  - btn[0]: if set_time != 0000, load count = set_time, clear prescaler, go to RUN. If set_time = 0000, ignore.
- RUN:
  - prescaler counts 0..TICKS_PER_SEC-1. At the terminal count it wraps to 0 and issues a one-cycle tick.
  - On tick, count decrements by one second in BCD with borrow chain: sec1 0 -> 9 borrows sec10; sec10 0 -> 5 borrows min1; min1 0 -> 9 borrows min10.
  - Tick with count = 0001 -> count = 0000, next state ALARM, alarm counter cleared.
  - btn[0] -> PAUSE; prescaler holds its value.
  - btn[3] -> IDLE; count discarded, set_time retained.
  - btn[1] and btn[2] are ignored.
- PAUSE:
  - count and prescaler frozen.
  - btn[0] -> RUN, resuming from the held prescaler value (no lost or extra partial second).
  - btn[3] -> IDLE.
- ALARM:
  - A second prescaler drives the alarm counter.
  - After ALARM_SEC seconds, go to IDLE.
  - Any button pulse -> IDLE on the next edge. The button is consumed and has no further effect (e.g. btn[1] does not increment set_time).
- Simultaneous events in RUN:
  - tick + btn[0]: the decrement is applied and state goes to PAUSE. If that decrement reaches 0000, ALARM wins.
  - tick + btn[3]: IDLE wins and count is not updated.
- Latency: each button takes effect on the clk edge that samples the pulse. value and alarm reflect the change on the following cycle.
- Reset mid-operation, in any state: immediate return to reset values; set_time is lost.

Test Plan (TICKS_PER_SEC=10, ALARM_SEC=3):
- Reset, then btn[2] x2 and btn[1] x5 -> value = 16'h0205, state IDLE, running = 0. Then btn[1] x55 -> seconds wrap, value = 16'h0200.
- Set 00:02, btn[0] -> running = 1, value 0002 -> 0001 after 10 cycles -> 0000 after 20 cycles. alarm = 1 on the cycle after the second tick. alarm stays high 30 cycles, then falls; value returns to 16'h0002.
- Set 01:00, start, run 10 cycles -> value = 16'h0059, confirming the borrow chain. Set 10:00, run one tick -> 16'h0959.
- Start 00:05, btn[0] at prescaler = 4 -> PAUSE, value frozen for 50 idle cycles. btn[0] -> next tick arrives exactly 6 cycles later.
- In RUN, btn[3] and btn[0] in the same cycle -> IDLE, value = set_time. In ALARM, btn[1] pulse -> alarm = 0 next cycle and set_time unchanged. btn[0] with set_time = 0000 -> stays IDLE.
- Assert reset_p asynchronously mid-RUN between clk edges -> value = 0000, alarm = 0, running = 0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/cook_timer_sec.sv
// rtl/cook_timer_sec.sv - MM:SS countdown kitchen timer with alarm, packed BCD display output

module cook_timer_sec #(
   parameter int TICKS_PER_SEC = 100000000,
   parameter int ALARM_SEC     = 10
) (
   input  logic        clk,
   input  logic        reset_p,
   input  logic [3:0]  btn_pedge,
   output logic [15:0] value,
   output logic        alarm,
   output logic        running
);

   localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam int AW = (ALARM_SEC > 1) ? $clog2(ALARM_SEC) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);
   localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_SEC - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_PAUSE = 2'd2,
      S_ALARM = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [15:0]     set_q, set_d;
   logic [15:0]     count_q, count_d;
   logic [PW-1:0]   presc_q, presc_d;
   logic [PW-1:0]   apresc_q, apresc_d;
   logic [AW-1:0]   acnt_q, acnt_d;
   logic            tick;
   logic            atick;

   // Seconds field +1, wrapping 59 -> 00 without touching minutes.
   function automatic logic [7:0] sec_inc(input logic [7:0] s);
      if (s == 8'h59)
         return 8'h00;
      else if (s[3:0] == 4'd9)
         return {s[7:4] + 4'd1, 4'd0};
      else
         return {s[7:4], s[3:0] + 4'd1};
   endfunction

   // Minutes field +1, wrapping 99 -> 00.
   function automatic logic [7:0] min_inc(input logic [7:0] m);
      if (m == 8'h99)
         return 8'h00;
      else if (m[3:0] == 4'd9)
         return {m[7:4] + 4'd1, 4'd0};
      else
         return {m[7:4], m[3:0] + 4'd1};
   endfunction

   // One-second BCD decrement with borrow chain; 0000 saturates (never reached in RUN).
   function automatic logic [15:0] bcd_dec(input logic [15:0] c);
      logic [3:0] m10, m1, s10, s1;
      m10 = c[15:12];
      m1  = c[11:8];
      s10 = c[7:4];
      s1  = c[3:0];
      if (c == 16'h0000)
         return 16'h0000;
      if (s1 != 4'd0) begin
         s1 = s1 - 4'd1;
      end else begin
         s1 = 4'd9;
         if (s10 != 4'd0) begin
            s10 = s10 - 4'd1;
         end else begin
            s10 = 4'd5;
            if (m1 != 4'd0) begin
               m1 = m1 - 4'd1;
            end else begin
               m1  = 4'd9;
               m10 = m10 - 4'd1;
            end
         end
      end
      return {m10, m1, s10, s1};
   endfunction

   assign tick  = (presc_q == PRESC_LAST);
   assign atick = (apresc_q == PRESC_LAST);

   // State and datapath registers.
   always_ff @(posedge clk or posedge reset_p) begin
      if (reset_p) begin
         state_q  <= S_IDLE;
         set_q    <= 16'h0000;
         count_q  <= 16'h0000;
         presc_q  <= '0;
         apresc_q <= '0;
         acnt_q   <= '0;
      end else begin
         state_q  <= state_d;
         set_q    <= set_d;
         count_q  <= count_d;
         presc_q  <= presc_d;
         apresc_q <= apresc_d;
         acnt_q   <= acnt_d;
      end
   end

   // Next-state logic; buttons resolved by priority clear > start/pause > min > sec.
   always_comb begin
      state_d  = state_q;
      set_d    = set_q;
      count_d  = count_q;
      presc_d  = presc_q;
      apresc_d = apresc_q;
      acnt_d   = acnt_q;
      case (state_q)
         S_IDLE: begin
            if (btn_pedge[3]) begin
               set_d = 16'h0000;
            end else if (btn_pedge[0]) begin
               if (set_q != 16'h0000) begin
                  count_d = set_q;
                  presc_d = '0;
                  state_d = S_RUN;
               end
            end else if (btn_pedge[2]) begin
               set_d[15:8] = min_inc(set_q[15:8]);
            end else if (btn_pedge[1]) begin
               set_d[7:0] = sec_inc(set_q[7:0]);
            end
         end
         S_RUN: begin
            if (btn_pedge[3]) begin
               state_d = S_IDLE;
            end else if (tick) begin
               presc_d = '0;
               count_d = bcd_dec(count_q);
               if (count_q == 16'h0001) begin
                  state_d  = S_ALARM;
                  apresc_d = '0;
                  acnt_d   = '0;
               end else if (btn_pedge[0]) begin
                  state_d = S_PAUSE;
               end
            end else if (btn_pedge[0]) begin
               // Prescaler holds so the partial second resumes exactly.
               state_d = S_PAUSE;
            end else begin
               presc_d = presc_q + 1'b1;
            end
         end
         S_PAUSE: begin
            if (btn_pedge[3])
               state_d = S_IDLE;
            else if (btn_pedge[0])
               state_d = S_RUN;
         end
         S_ALARM: begin
            if (|btn_pedge) begin
               state_d = S_IDLE;
            end else if (atick) begin
               apresc_d = '0;
               if (acnt_q == ALARM_LAST)
                  state_d = S_IDLE;
               else
                  acnt_d = acnt_q + 1'b1;
            end else begin
               apresc_d = apresc_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign value   = (state_q == S_IDLE) ? set_q : count_q;
   assign alarm   = (state_q == S_ALARM);
   assign running = (state_q == S_RUN);

endmodule

// File: tb/tb_cook_timer_sec.sv
// tb/tb_cook_timer_sec.sv - self-checking bench for cook_timer_sec against a seconds-based model

module tb_cook_timer_sec;

   localparam int T = 10;
   localparam int A = 3;

   logic        clk;
   logic        reset_p;
   logic [3:0]  btn_pedge;
   logic [15:0] value;
   logic        alarm;
   logic        running;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: mode 0 idle, 1 run, 2 pause, 3 alarm; time kept as plain seconds.
   int m_mode;
   int m_set_min, m_set_sec;
   int m_left;
   int m_phase;
   int m_al_phase, m_al_sec;

   cook_timer_sec #(.TICKS_PER_SEC(T), .ALARM_SEC(A)) dut (
      .clk       (clk),
      .reset_p   (reset_p),
      .btn_pedge (btn_pedge),
      .value     (value),
      .alarm     (alarm),
      .running   (running)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [15:0] to_bcd(input int mm, input int ss);
      return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
   endfunction

   function automatic logic [15:0] model_value();
      if (m_mode == 0)
         return to_bcd(m_set_min, m_set_sec);
      else
         return to_bcd(m_left / 60, m_left % 60);
   endfunction

   task automatic model_reset();
      m_mode = 0;
      m_set_min = 0;
      m_set_sec = 0;
      m_left = 0;
      m_phase = 0;
      m_al_phase = 0;
      m_al_sec = 0;
   endtask

   task automatic model_step(input logic [3:0] b);
      bit tk;
      case (m_mode)
         0: begin
            if (b[3]) begin
               m_set_min = 0;
               m_set_sec = 0;
            end else if (b[0]) begin
               if (m_set_min != 0 || m_set_sec != 0) begin
                  m_left = m_set_min * 60 + m_set_sec;
                  m_phase = 0;
                  m_mode = 1;
               end
            end else if (b[2]) begin
               m_set_min = (m_set_min + 1) % 100;
            end else if (b[1]) begin
               m_set_sec = (m_set_sec + 1) % 60;
            end
         end
         1: begin
            tk = (m_phase == T - 1);
            if (b[3]) begin
               m_mode = 0;
            end else if (tk) begin
               m_phase = 0;
               m_left = m_left - 1;
               if (m_left == 0) begin
                  m_mode = 3;
                  m_al_phase = 0;
                  m_al_sec = 0;
               end else if (b[0]) begin
                  m_mode = 2;
               end
            end else if (b[0]) begin
               m_mode = 2;
            end else begin
               m_phase = m_phase + 1;
            end
         end
         2: begin
            if (b[3]) m_mode = 0;
            else if (b[0]) m_mode = 1;
         end
         default: begin
            if (b != 4'd0) begin
               m_mode = 0;
            end else if (m_al_phase == T - 1) begin
               m_al_phase = 0;
               m_al_sec = m_al_sec + 1;
               if (m_al_sec == A) m_mode = 0;
            end else begin
               m_al_phase = m_al_phase + 1;
            end
         end
      endcase
   endtask

   task automatic check_model();
      check("value", {16'd0, value}, {16'd0, model_value()});
      check("alarm", {31'd0, alarm}, {31'd0, (m_mode == 3)});
      check("running", {31'd0, running}, {31'd0, (m_mode == 1)});
   endtask

   // One clock with button pattern b held across the rising edge; outputs compared at the falling edge.
   task automatic cyc(input logic [3:0] b);
      btn_pedge = b;
      @(posedge clk);
      model_step(b);
      @(negedge clk);
      btn_pedge = 4'd0;
      check_model();
   endtask

   initial begin
      int r;
      logic [3:0] b;
      reset_p = 1'b1;
      btn_pedge = 4'd0;
      model_reset();
      repeat (2) @(negedge clk);
      check("rst_value", {16'd0, value}, 32'h0000);
      check("rst_alarm", {31'd0, alarm}, 32'd0);
      check("rst_running", {31'd0, running}, 32'd0);
      reset_p = 1'b0;
      cyc(4'd0);

      // Setting and seconds wrap
      repeat (2) cyc(4'b0100);
      repeat (5) cyc(4'b0010);
      check("set_0205", {16'd0, value}, 32'h0205);
      check("set_idle", {31'd0, running}, 32'd0);
      repeat (55) cyc(4'b0010);
      check("sec_wrap", {16'd0, value}, 32'h0200);

      // 00:02 countdown into alarm and auto-return
      cyc(4'b1000);
      repeat (2) cyc(4'b0010);
      cyc(4'b0001);
      check("start_run", {31'd0, running}, 32'd1);
      check("start_val", {16'd0, value}, 32'h0002);
      repeat (9) cyc(4'd0);
      check("pre_tick1", {16'd0, value}, 32'h0002);
      cyc(4'd0);
      check("tick1", {16'd0, value}, 32'h0001);
      repeat (9) cyc(4'd0);
      check("pre_tick2", {31'd0, alarm}, 32'd0);
      cyc(4'd0);
      check("tick2_val", {16'd0, value}, 32'h0000);
      check("tick2_alarm", {31'd0, alarm}, 32'd1);
      repeat (29) cyc(4'd0);
      check("alarm_hold", {31'd0, alarm}, 32'd1);
      cyc(4'd0);
      check("alarm_end", {31'd0, alarm}, 32'd0);
      check("alarm_ret", {16'd0, value}, 32'h0002);

      // Borrow chain
      cyc(4'b1000);
      cyc(4'b0100);
      cyc(4'b0001);
      repeat (10) cyc(4'd0);
      check("borrow_0059", {16'd0, value}, 32'h0059);
      cyc(4'b1000);
      check("clr_keep_set", {16'd0, value}, 32'h0100);
      cyc(4'b1000);
      repeat (10) cyc(4'b0100);
      cyc(4'b0001);
      repeat (10) cyc(4'd0);
      check("borrow_0959", {16'd0, value}, 32'h0959);
      cyc(4'b1000);

      // Pause at prescaler 4 and exact resume
      cyc(4'b1000);
      repeat (5) cyc(4'b0010);
      cyc(4'b0001);
      repeat (4) cyc(4'd0);
      cyc(4'b0001);
      check("pause_run", {31'd0, running}, 32'd0);
      repeat (50) cyc(4'd0);
      check("pause_frozen", {16'd0, value}, 32'h0005);
      cyc(4'b0001);
      repeat (5) cyc(4'd0);
      check("resume_pre", {16'd0, value}, 32'h0005);
      cyc(4'd0);
      check("resume_tick", {16'd0, value}, 32'h0004);

      // Clear + start together in RUN
      cyc(4'b1001);
      check("clr_start_run", {31'd0, running}, 32'd0);
      check("clr_start_val", {16'd0, value}, 32'h0005);

      // Tick coinciding with pause, then with clear
      cyc(4'b1000);
      repeat (3) cyc(4'b0010);
      cyc(4'b0001);
      repeat (9) cyc(4'd0);
      cyc(4'b0001);
      check("tick_pause_val", {16'd0, value}, 32'h0002);
      check("tick_pause_run", {31'd0, running}, 32'd0);
      cyc(4'b0001);
      repeat (9) cyc(4'd0);
      cyc(4'b1000);
      check("tick_clr_val", {16'd0, value}, 32'h0003);

      // Tick to zero with pause goes to alarm; button in alarm is consumed
      cyc(4'b1000);
      cyc(4'b0010);
      cyc(4'b0001);
      repeat (9) cyc(4'd0);
      cyc(4'b0001);
      check("zero_pause_alarm", {31'd0, alarm}, 32'd1);
      cyc(4'b0010);
      check("alarm_btn_off", {31'd0, alarm}, 32'd0);
      check("alarm_btn_set", {16'd0, value}, 32'h0001);

      // Start ignored with 00:00
      cyc(4'b1000);
      cyc(4'b0001);
      check("start_zero", {31'd0, running}, 32'd0);

      // Asynchronous reset between edges in RUN
      cyc(4'b0010);
      cyc(4'b0001);
      repeat (3) cyc(4'd0);
      #2 reset_p = 1'b1;
      #1;
      check("areset_value", {16'd0, value}, 32'h0000);
      check("areset_alarm", {31'd0, alarm}, 32'd0);
      check("areset_running", {31'd0, running}, 32'd0);
      model_reset();
      @(negedge clk);
      reset_p = 1'b0;
      cyc(4'd0);

      // Randomized traffic against the model
      for (int i = 0; i < 4000; i++) begin
         r = $urandom_range(0, 99);
         if (r < 3)
            b = 4'(1 << $urandom_range(0, 3));
         else if (r < 5)
            b = 4'($urandom_range(1, 15));
         else if (r < 12 && m_mode == 0)
            b = 4'b0010;
         else
            b = 4'd0;
         cyc(b);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
